// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with a post-reset zero sweep.
// Reads are combinational and bypass same-cycle writes, with port 1 taking priority.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic ready;
    logic we0;
    logic we1;

    // Writes only land in READY outside reset; entry 0 is read-only when hardwired.
    assign ready = (state_q == READY) && !rst;
    assign we0   = ready && wr_en0 && !(ZERO_REG && (wr_addr0 == '0));
    assign we1   = ready && wr_en1 && !(ZERO_REG && (wr_addr1 == '0));
    assign busy  = (state_q == CLEAR);

    // Sweep controller: walk clr_ptr across every entry, then open for writes.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                clr_ptr_d = '0;
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Controller state register with synchronous reset back to the sweep start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next storage contents: sweep zero, then port 0, then port 1 (port 1 wins ties).
    always_comb begin
        mem_d = mem_q;
        if (!rst && (state_q == CLEAR)) begin
            mem_d[clr_ptr_q] = '0;
        end
        if (we0) begin
            mem_d[wr_addr0] = wr_data0;
        end
        if (we1) begin
            mem_d[wr_addr1] = wr_data1;
        end
    end

    // Storage array; contents are defined by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read port 0: zero while not ready, then bypass, then stored data.
    always_comb begin
        rd_data0 = '0;
        if (!ready) begin
            rd_data0 = '0;
        end else if (ZERO_REG && (rd_addr0 == '0)) begin
            rd_data0 = '0;
        end else if (we1 && (wr_addr1 == rd_addr0)) begin
            rd_data0 = wr_data1;
        end else if (we0 && (wr_addr0 == rd_addr0)) begin
            rd_data0 = wr_data0;
        end else begin
            rd_data0 = mem_q[rd_addr0];
        end
    end

    // Read port 1: identical selection to port 0.
    always_comb begin
        rd_data1 = '0;
        if (!ready) begin
            rd_data1 = '0;
        end else if (ZERO_REG && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if (we1 && (wr_addr1 == rd_addr1)) begin
            rd_data1 = wr_data1;
        end else if (we0 && (wr_addr0 == rd_addr1)) begin
            rd_data1 = wr_data0;
        end else begin
            rd_data1 = mem_q[rd_addr1];
        end
    end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: sweep timing, bypass, collisions, zero register.
// Two instances share stimulus; one hardwires entry 0, the other does not.
module tb_regfile_2w2r;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic        wr_en0;
    logic [4:0]  wr_addr0;
    logic [31:0] wr_data0;
    logic        wr_en1;
    logic [4:0]  wr_addr1;
    logic [31:0] wr_data1;

    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic        a_busy, b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .rd_addr0(rd_addr0), .rd_data0(a_rd0),
        .rd_addr1(rd_addr1), .rd_data1(a_rd1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy(a_busy)
    );

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr0(rd_addr0), .rd_data0(b_rd0),
        .rd_addr1(rd_addr1), .rd_data1(b_rd1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr0 = '0; rd_addr1 = '0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;

        // Reset for one edge, then measure the sweep length.
        tick();
        rst = 1'b0;
        #1;
        chk("busy_after_rst", {31'b0, a_busy}, 32'd1);
        n = 0;
        while (a_busy && n < 100) begin
            n++;
            tick();
            #1;
        end
        chk("sweep_cycles", n, 32'd32);
        chk("busy_done", {31'b0, a_busy}, 32'd0);
        chk("busy_done_b", {31'b0, b_busy}, 32'd0);

        // Every entry reads zero after the sweep, on both ports.
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            chk("swept_rd0", a_rd0, 32'h0);
            chk("swept_rd1", a_rd1, 32'h0);
        end

        // Port 0 write with same-cycle bypass, then stored read on port 1.
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'hDEADBEEF;
        rd_addr0 = 5'd9; rd_addr1 = 5'd10;
        #1;
        chk("bypass_p0", a_rd0, 32'hDEADBEEF);
        chk("no_bypass_other", a_rd1, 32'h0);
        tick();
        idle();
        rd_addr0 = 5'd10; rd_addr1 = 5'd9;
        #1;
        chk("stored_9", a_rd1, 32'hDEADBEEF);
        chk("untouched_10", a_rd0, 32'h0);

        // Same-address collision: port 1 wins in bypass and in storage.
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11111111;
        wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22222222;
        rd_addr0 = 5'd7; rd_addr1 = 5'd7;
        #1;
        chk("coll_bypass0", a_rd0, 32'h22222222);
        chk("coll_bypass1", a_rd1, 32'h22222222);
        tick();
        idle();
        #1;
        chk("coll_stored0", a_rd0, 32'h22222222);
        chk("coll_stored1", a_rd1, 32'h22222222);

        // Distinct-address dual write commits both.
        wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 32'hA;
        wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'hB;
        rd_addr0 = 5'd2; rd_addr1 = 5'd1;
        #1;
        chk("dual_byp0", a_rd0, 32'hB);
        chk("dual_byp1", a_rd1, 32'hA);
        tick();
        idle();
        rd_addr0 = 5'd1; rd_addr1 = 5'd2;
        #1;
        chk("dual_rd0", a_rd0, 32'hA);
        chk("dual_rd1", a_rd1, 32'hB);
        chk("keep_9", a_rd0 ^ 32'hA ^ b_rd0 ^ 32'hA, 32'h0);

        // Entry 0: hardwired in dut_a, ordinary in dut_b.
        wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFFFFFF;
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        #1;
        chk("zr_byp_a", a_rd0, 32'h0);
        chk("zr_byp_b", b_rd0, 32'hFFFFFFFF);
        tick();
        idle();
        #1;
        chk("zr_after_a", a_rd0, 32'h0);
        chk("zr_after_b", b_rd0, 32'hFFFFFFFF);
        chk("zr_after_b1", b_rd1, 32'hFFFFFFFF);

        // Reset from READY: reads forced to zero while rst is high.
        rst = 1'b1;
        rd_addr0 = 5'd9; rd_addr1 = 5'd7;
        #1;
        chk("rst_rd0", a_rd0, 32'h0);
        chk("rst_rd1", a_rd1, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'b0, a_busy}, 32'd1);

        // Abort the sweep at cycle 10 with writes held on throughout.
        repeat (10) tick();
        chk("mid_busy", {31'b0, a_busy}, 32'd1);
        rst = 1'b1;
        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h33333333;
        wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 32'h44444444;
        rd_addr0 = 5'd3; rd_addr1 = 5'd4;
        tick();
        rst = 1'b0;
        #1;
        n = 0;
        while (a_busy && n < 100) begin
            if (a_rd0 !== 32'h0 || a_rd1 !== 32'h0) begin
                chk("busy_rd0", a_rd0, 32'h0);
                chk("busy_rd1", a_rd1, 32'h0);
            end
            n++;
            tick();
            #1;
        end
        chk("resweep_cycles", n, 32'd32);
        idle();
        #1;
        chk("ign_wr3", a_rd0, 32'h0);
        chk("ign_wr4", a_rd1, 32'h0);
        rd_addr0 = 5'd9; rd_addr1 = 5'd0;
        #1;
        chk("cleared_9", a_rd0, 32'h0);
        chk("cleared_0_b", b_rd1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
